// File: rtl/delta_decoder_accum_if.sv
// Pin-level bundle of the delta decoder: deltas/strobe/load in, acc/ovf/upd out.
// Pin map: delta=io_in[5:2], strobe=io_in[6], load=io_in[7]; acc=io_out[5:0], ovf=io_out[6], upd=io_out[7].
interface delta_decoder_accum_if;
   // Handshake: a rising edge on strobe (add) or load (replace) requests one update while
   // delta is held stable; upd answers with a single-cycle pulse alongside the new acc.
   logic [3:0] delta;
   logic       strobe;
   logic       load;
   logic [5:0] acc;
   logic       ovf;
   logic       upd;

   modport master (output delta, output strobe, output load,
                   input  acc,   input  ovf,    input  upd);
   modport slave  (input  delta, input  strobe, input  load,
                   output acc,   output ovf,    output upd);
endinterface

// File: rtl/delta_decoder_accum.sv
// Delta decoder: integrates synchronized 4-bit signed deltas into an ACC_W-bit accumulator.
// Optional macro DELTA_DEC_SAT_EN makes overflowing adds saturate instead of wrapping.
module delta_decoder_accum #(
   parameter int ACC_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   delta_decoder_accum_if.slave  bus_io
);

   localparam int MSB = ACC_W - 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic             strobe_s1_q, strobe_s2_q, strobe_s3_q;
   logic             load_s1_q, load_s2_q, load_s3_q;
   logic [3:0]       delta_s1_q, delta_s2_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             upd_q, upd_d;

   logic             strobe_edge, load_edge;
   logic [ACC_W-1:0] d_ext, sum;
   logic             add_ovf;
   logic [5:0]       acc_ext;

   assign strobe_edge = strobe_s2_q & ~strobe_s3_q;
   assign load_edge   = load_s2_q & ~load_s3_q;

   always_comb begin
      d_ext   = ACC_W'(signed'(delta_s2_q));
      sum     = acc_q + d_ext;
      add_ovf = (acc_q[MSB] == d_ext[MSB]) && (sum[MSB] != acc_q[MSB]);
   end

   // Load takes priority over a coincident strobe; the add is dropped.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      upd_d = 1'b0;
      if (load_edge) begin
         acc_d = d_ext;
         ovf_d = 1'b0;
         upd_d = 1'b1;
      end else if (strobe_edge) begin
         acc_d = sum;
         upd_d = 1'b1;
         if (add_ovf) begin
            ovf_d = 1'b1;
`ifdef DELTA_DEC_SAT_EN
            acc_d = acc_q[MSB] ? ACC_MIN : ACC_MAX;
`else
            acc_d = sum;
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         strobe_s1_q <= 1'b0;
         strobe_s2_q <= 1'b0;
         strobe_s3_q <= 1'b0;
         load_s1_q   <= 1'b0;
         load_s2_q   <= 1'b0;
         load_s3_q   <= 1'b0;
         delta_s1_q  <= '0;
         delta_s2_q  <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         upd_q       <= 1'b0;
      end else begin
         strobe_s1_q <= bus_io.strobe;
         strobe_s2_q <= strobe_s1_q;
         strobe_s3_q <= strobe_s2_q;
         load_s1_q   <= bus_io.load;
         load_s2_q   <= load_s1_q;
         load_s3_q   <= load_s2_q;
         delta_s1_q  <= bus_io.delta;
         delta_s2_q  <= delta_s1_q;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         upd_q       <= upd_d;
      end
   end

   // Bits above ACC_W read as zero on the 6-bit pin field.
   always_comb begin
      acc_ext            = '0;
      acc_ext[ACC_W-1:0] = acc_q;
   end

   assign bus_io.acc = acc_ext;
   assign bus_io.ovf = ovf_q;
   assign bus_io.upd = upd_q;

endmodule

// File: tb/tb_delta_decoder_accum.sv
// Randomized and directed bench for delta_decoder_accum against an integer reference model.
module tb_delta_decoder_accum;

   localparam int ACC_W = 6;
   localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
   localparam int MINV  = -(1 << (ACC_W - 1));
   localparam int MASK  = (1 << ACC_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_acc  = 0;
   bit   m_ovf  = 1'b0;

   delta_decoder_accum_if dut_if ();

   delta_decoder_accum #(.ACC_W(ACC_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (dut_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sext4(input logic [3:0] d);
      logic signed [3:0] ds;
      ds = d;
      return int'(ds);
   endfunction

   // Reference: integer arithmetic, then wrap or clamp back into the ACC_W range.
   function automatic void model_op(input bit s, input bit l, input logic [3:0] d);
      int r;
      if (l) begin
         m_acc = sext4(d);
         m_ovf = 1'b0;
      end else if (s) begin
         r = m_acc + sext4(d);
         if (r > MAXV || r < MINV) begin
            m_ovf = 1'b1;
`ifdef DELTA_DEC_SAT_EN
            r = (r > MAXV) ? MAXV : MINV;
`else
            r = (r > MAXV) ? r - (1 << ACC_W) : r + (1 << ACC_W);
`endif
         end
         m_acc = r;
      end
   endfunction

   task automatic check_outputs(input string tag, input int e_acc, input bit e_ovf, input bit e_upd);
      chk({tag, ".acc"}, 32'(dut_if.acc), 32'(e_acc & MASK));
      chk({tag, ".ovf"}, 32'(dut_if.ovf), 32'(e_ovf));
      chk({tag, ".upd"}, 32'(dut_if.upd), 32'(e_upd));
   endtask

   // Raise strobe/load with delta, hold for 'hold' sampled edges, watch the response window.
   task automatic do_op(input string tag, input bit s, input bit l, input logic [3:0] d,
                        input int hold, input bit rel);
      int old_acc;
      bit old_ovf;
      @(negedge clk);
      dut_if.delta  = d;
      dut_if.strobe = s;
      dut_if.load   = l;
      if (rel) rst_n = 1'b1;
      old_acc = m_acc;
      old_ovf = m_ovf;
      model_op(s, l, d);
      for (int c = 1; c <= hold + 4; c++) begin
         @(negedge clk);
         if (c == hold) begin
            dut_if.strobe = 1'b0;
            dut_if.load   = 1'b0;
         end
         if (c < 3) check_outputs(tag, old_acc, old_ovf, 1'b0);
         else       check_outputs(tag, m_acc, m_ovf, (s || l) && c == 3);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      dut_if.delta  = 4'($urandom);
      dut_if.strobe = 1'($urandom);
      dut_if.load   = 1'($urandom);

      // Reset with random pins, then release with strobe/load low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outputs("reset", 0, 1'b0, 1'b0);
         dut_if.delta  = 4'($urandom);
         dut_if.strobe = 1'($urandom);
         dut_if.load   = 1'($urandom);
      end
      @(negedge clk);
      dut_if.strobe = 1'b0;
      dut_if.load   = 1'b0;
      rst_n         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_outputs("post_reset", 0, 1'b0, 1'b0);
      end

      do_op("add_p3", 1'b1, 1'b0, 4'h3, 1, 1'b0);
      chk("add_p3.val", 32'(dut_if.acc), 32'h03);
      do_op("add_p5", 1'b1, 1'b0, 4'h5, 1, 1'b0);
      chk("add_p5.val", 32'(dut_if.acc), 32'h08);
      do_op("add_m2", 1'b1, 1'b0, 4'hE, 1, 1'b0);
      chk("add_m2.val", 32'(dut_if.acc), 32'h06);

      do_op("load_m4", 1'b0, 1'b1, 4'hC, 1, 1'b0);
      chk("load_m4.val", 32'(dut_if.acc), 32'h3C);
      do_op("add_p4", 1'b1, 1'b0, 4'h4, 1, 1'b0);
      chk("add_p4.val", 32'(dut_if.acc), 32'h00);

      // Overflow sequence from zero.
      do_op("load_0", 1'b0, 1'b1, 4'h0, 1, 1'b0);
      for (int i = 0; i < 5; i++) do_op("add_p7", 1'b1, 1'b0, 4'h7, 1, 1'b0);
`ifdef DELTA_DEC_SAT_EN
      chk("ovf_sat.val", 32'(dut_if.acc), 32'h1F);
`else
      chk("ovf_wrap.val", 32'(dut_if.acc), 32'h23);
`endif
      chk("ovf_set", 32'(dut_if.ovf), 32'h1);
      do_op("ovf_sticky", 1'b1, 1'b0, 4'h1, 1, 1'b0);
      chk("ovf_sticky.flag", 32'(dut_if.ovf), 32'h1);
      do_op("ovf_clear", 1'b0, 1'b1, 4'h0, 1, 1'b0);
      chk("ovf_clear.flag", 32'(dut_if.ovf), 32'h0);

      do_op("held10", 1'b1, 1'b0, 4'h2, 10, 1'b0);
      chk("held10.val", 32'(dut_if.acc), 32'h02);
      do_op("both", 1'b1, 1'b1, 4'h5, 1, 1'b0);
      chk("both.val", 32'(dut_if.acc), 32'h05);

      // Reset mid-run with a strobe edge in flight.
      do_op("pre_mid_ld", 1'b0, 1'b1, 4'h3, 1, 1'b0);
      do_op("pre_mid_add", 1'b1, 1'b0, 4'h5, 1, 1'b0);
      chk("pre_mid.val", 32'(dut_if.acc), 32'h08);
      @(negedge clk);
      dut_if.delta  = 4'h2;
      dut_if.strobe = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      dut_if.strobe = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_outputs("mid_reset", 0, 1'b0, 1'b0);
      end

      // Strobe already high when reset releases is one accepted edge.
      @(negedge clk);
      rst_n         = 1'b0;
      dut_if.delta  = 4'h2;
      dut_if.strobe = 1'b1;
      repeat (2) @(negedge clk);
      m_acc = 0;
      m_ovf = 1'b0;
      do_op("strobe_at_rel", 1'b1, 1'b0, 4'h2, 3, 1'b1);
      chk("strobe_at_rel.val", 32'(dut_if.acc), 32'h02);

      // Random mix of adds, loads and coincident edges.
      for (int i = 0; i < 60; i++) begin
         int k;
         k = $urandom_range(0, 4);
         do_op("rand", k != 2, k >= 2 && k != 4 ? 1'b1 : 1'b0, 4'($urandom),
               $urandom_range(1, 3), 1'b0);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check_outputs("rand_idle", m_acc, m_ovf, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
